ball_ctl: RTL
=============

# ball_ctl

Per-frame ball physics controller feeding the ball sprite drawing stage. It integrates the ball's position and velocity once per video frame under constant gravity. It takes the per-pixel player and net collision flags that the drawing stage produces during active video, accumulates them, and resolves them into bounces. It outputs the sprite's top-left corner `xpos`/`ypos` and one-cycle point pulses when the ball reaches the floor.

## Interface
- `X_MIN`, 0: left wall, sprite left edge in px
- `X_MAX`, 736: right wall limit for sprite left edge (800 − 64)
- `FLOOR_Y`, 536: ball-landed threshold for sprite top (600 − 64)
- `NET_X`, 400: court centre in px
- `SERVE_X1` / `SERVE_X2`, 150 / 586: serve x for player 1 / player 2
- `SERVE_Y`, 100: serve y
- `GRAVITY`, 4: vy increment per frame, Q6.4 (1/16 px)
- `BOUNCE_VY`, 96: magnitude of upward vy after a player hit, Q6.4
- `VX_HIT`, 48: magnitude of vx after a player hit, Q6.4
- `VMAX`, 160: velocity clamp magnitude, Q6.4
- `HOLD_FRAMES`, 60: frames the ball rests on the floor before re-serve
- `pclk` in 1: pixel clock
- `rst` in 1: synchronous, active-high reset
- `vblnk` in 1: vertical blank from timing chain; rising edge = frame tick
- `start` in 1: level; launches a serve while in SERVE
- `pl1_col`, `pl2_col`, `net_col` in 1 each: per-pixel collision flags from drawing stage
- `xpos`, `ypos` out 12: sprite top-left, integer px, registered
- `point_pl1`, `point_pl2` out 1: one-cycle score pulses
- `in_play` out 1: high in FLY

## Operation
- State: `px`, `py` unsigned 16-bit Q12.4; `vx`, `vy` signed 10-bit Q6.4; `xpos = px[15:4]`, `ypos = py[15:4]`.
- Tick: `tick = vblnk & ~vblnk_d`, with `vblnk_d` registered.
- Collision latches: `c1`, `c2`, `cn` are set by their flags in any cycle and cleared on the tick cycle. A flag high on the tick cycle itself is kept for the next frame.
- SERVE: holds `px` at `SERVE_Xn` per `srv` (0 = player 1, reset value 0), `py = SERVE_Y`, `vx = vy = 0`. When `tick & start`, go to FLY.
- FLY, on each tick, resolve the first matching rule:
  - Player hit: (`c1` and ball centre `xpos+32 < NET_X`), or `c2`. Then `vy = −BOUNCE_VY`, `vx = +VX_HIT` for player 1 or `−VX_HIT` for player 2.
  - Otherwise `cn`: `vx = −vx`.
  - Otherwise `vy = vy + GRAVITY`.
- Walls: if `px + vx` falls below `X_MIN`, clamp `px` to `X_MIN` and set `vx = |vx|`; symmetric at `X_MAX` with `vx = −|vx|`. `py` saturates at 0; a ceiling hit sets `vy = |vy|`.
- Position update: `px += vx`, `py += vy`, using the velocity values computed this tick.
- Floor: if the new `py ≥ FLOOR_Y<<4`, clamp `py` there, zero `vx`/`vy`, and go to SCORED. Pulse `point_pl2` if landing `xpos+32 < NET_X`, else `point_pl1`. Set `srv` to the scorer.
- SCORED: count `HOLD_FRAMES` ticks, then go to SERVE. Ignore collisions and `start`.

## Timing
- `xpos`/`ypos` change only in the cycle after a tick, so they are stable for the whole active frame.
- Point pulse is high exactly one `pclk` cycle, the cycle after the landing tick.
- `start` is sampled only on tick cycles in SERVE.
- Reset: state SERVE, `srv = 0`, `xpos = SERVE_X1`, `ypos = SERVE_Y`, velocities 0, latches 0, `vblnk_d = 0`, points 0, `in_play = 0`, hold counter 0.
- Reset during FLY or SCORED aborts immediately to the reset state; no point pulse is emitted.

## Configuration
- `BALL_VCLAMP_EN` defined: after every velocity update, saturate `vx` and `vy` to ±`VMAX`.
- `BALL_VCLAMP_EN` undefined: no clamp; the 10-bit signed velocity wraps.

## Test plan
- Reset, then 3 ticks with `start = 0`: `xpos = 150`, `ypos = 100`, `in_play = 0` throughout.
- `start` at tick 0, no collisions: `vy` after n ticks is `4n`; `ypos` after 10 ticks is 100 + (4·55)>>4 = 113.
- Free fall from serve at x=150: lands left of net, `point_pl2` single-cycle pulse; then SERVE after 60 ticks at x=586 (scorer player 2 serves).
- `pl1_col` pulse mid-frame with `xpos = 150`: next tick `vy = −96`, `vx = +48`, `xpos` becomes 153.
- `pl1_col` asserted exactly on the tick cycle: no bounce this tick; bounce applied at the following tick.
- With `vx = +48` near the right wall, ball is placed so the next step crosses `X_MAX`: `xpos = 736`, `vx = −48`. With `BALL_VCLAMP_EN` and 60 free-fall ticks, `vy` saturates at 160.

Source files
------------

// File: rtl/ball_ctl.sv
// ball_ctl: per-frame ball physics for the ball sprite stage.
//   Integrates position/velocity once per video frame (rising edge of vblnk)
//   under constant gravity, folds per-pixel collision flags gathered during
//   the frame into bounces, and reports floor landings as point pulses.
// Ports:
//   pclk, rst (sync, active high)      clock / reset
//   vblnk                              vertical blank, rising edge = frame tick
//   start                              serve launch, sampled on ticks in SERVE
//   pl1_col, pl2_col, net_col          per-pixel collision flags
//   xpos, ypos [11:0]                  sprite top-left, integer px
//   point_pl1, point_pl2               one-cycle score pulses
//   in_play                            ball is in flight
// Build option: define BALL_VCLAMP_EN to saturate vx/vy to +/-VMAX after each
//   velocity update; otherwise the 10-bit signed velocities wrap.
module ball_ctl #(
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 736,
    parameter int FLOOR_Y     = 536,
    parameter int NET_X       = 400,
    parameter int SERVE_X1    = 150,
    parameter int SERVE_X2    = 586,
    parameter int SERVE_Y     = 100,
    parameter int GRAVITY     = 4,
    parameter int BOUNCE_VY   = 96,
    parameter int VX_HIT      = 48,
    parameter int VMAX        = 160,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        start,
    input  logic        pl1_col,
    input  logic        pl2_col,
    input  logic        net_col,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        point_pl1,
    output logic        point_pl2,
    output logic        in_play
);

`ifdef BALL_VCLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    // Q12.4 positions, widened to 18-bit signed for overflow-free compares
    localparam logic signed [17:0] XMIN_Q  = 18'(X_MIN * 16);
    localparam logic signed [17:0] XMAX_Q  = 18'(X_MAX * 16);
    localparam logic signed [17:0] FLOOR_Q = 18'(FLOOR_Y * 16);
    localparam logic [15:0] SX1_Q = 16'(SERVE_X1 * 16);
    localparam logic [15:0] SX2_Q = 16'(SERVE_X2 * 16);
    localparam logic [15:0] SY_Q  = 16'(SERVE_Y * 16);
    localparam logic [12:0] NET_C = 13'(NET_X);
    // Q6.4 velocity constants, one guard bit above the 10-bit register
    localparam logic signed [10:0] BVY    = 11'(BOUNCE_VY);
    localparam logic signed [10:0] VXH    = 11'(VX_HIT);
    localparam logic signed [10:0] GRV    = 11'(GRAVITY);
    localparam logic signed [10:0] VMAX_S = 11'(VMAX);
    localparam logic signed [10:0] VMIN_S = -VMAX_S;

    typedef enum logic [1:0] {SERVE, FLY, SCORED} state_t;

    state_t             state, state_nx;
    logic [15:0]        px, py, px_nx, py_nx;
    logic signed [9:0]  vx, vy, vx_nx, vy_nx;
    logic               srv, srv_nx;
    logic [HW-1:0]      hold_cnt, hold_nx;
    logic               vblnk_d, tick;
    logic               c1, c2, cn;
    logic               pt1_nx, pt2_nx;
    logic               hit1;
    logic [12:0]        ctr_now, ctr_new;
    logic signed [10:0] vx_t, vy_t;
    logic signed [9:0]  vx_v, vy_v;
    logic signed [17:0] nx, ny;

    // Saturate when the clamp is built in, else drop the guard bit (wrap).
    function automatic logic signed [9:0] vfix(input logic signed [10:0] v);
        if (CLAMP_EN && v > VMAX_S) return VMAX_S[9:0];
        if (CLAMP_EN && v < VMIN_S) return VMIN_S[9:0];
        return v[9:0];
    endfunction

    function automatic logic signed [9:0] vabs(input logic signed [9:0] v);
        return v[9] ? -v : v;
    endfunction

    assign tick      = vblnk & ~vblnk_d;
    assign xpos      = px[15:4];
    assign ypos      = py[15:4];
    assign in_play   = (state == FLY);
    assign ctr_now   = {1'b0, px[15:4]} + 13'd32;

    always_comb begin
        state_nx = state;
        px_nx    = px;
        py_nx    = py;
        vx_nx    = vx;
        vy_nx    = vy;
        srv_nx   = srv;
        hold_nx  = hold_cnt;
        pt1_nx   = 1'b0;
        pt2_nx   = 1'b0;
        hit1     = c1 && (ctr_now < NET_C);
        vx_t     = '0;
        vy_t     = '0;
        vx_v     = '0;
        vy_v     = '0;
        nx       = '0;
        ny       = '0;
        ctr_new  = '0;
        case (state)
            SERVE: begin
                px_nx = srv ? SX2_Q : SX1_Q;
                py_nx = SY_Q;
                vx_nx = '0;
                vy_nx = '0;
                if (tick && start) state_nx = FLY;
            end
            FLY: if (tick) begin
                vx_t = {vx[9], vx};
                vy_t = {vy[9], vy};
                // player 1 only counts while the ball is on its side
                if (hit1 || c2) begin
                    vy_t = -BVY;
                    vx_t = hit1 ? VXH : -VXH;
                end else if (cn) begin
                    vx_t = -vx_t;
                end else begin
                    vy_t = vy_t + GRV;
                end
                vx_v = vfix(vx_t);
                vy_v = vfix(vy_t);

                nx = {2'b00, px} + {{8{vx_v[9]}}, vx_v};
                if (nx < XMIN_Q) begin
                    px_nx = XMIN_Q[15:0];
                    vx_v  = vabs(vx_v);
                end else if (nx > XMAX_Q) begin
                    px_nx = XMAX_Q[15:0];
                    vx_v  = -vabs(vx_v);
                end else begin
                    px_nx = nx[15:0];
                end

                ny = {2'b00, py} + {{8{vy_v[9]}}, vy_v};
                if (ny[17]) begin
                    py_nx = '0;
                    vy_v  = vabs(vy_v);
                end else begin
                    py_nx = ny[15:0];
                end
                vx_nx = vx_v;
                vy_nx = vy_v;

                if (!ny[17] && ny >= FLOOR_Q) begin
                    py_nx    = FLOOR_Q[15:0];
                    vx_nx    = '0;
                    vy_nx    = '0;
                    state_nx = SCORED;
                    hold_nx  = '0;
                    // landing on player 1's half scores for player 2
                    ctr_new  = {1'b0, px_nx[15:4]} + 13'd32;
                    if (ctr_new < NET_C) begin
                        pt2_nx = 1'b1;
                        srv_nx = 1'b1;
                    end else begin
                        pt1_nx = 1'b1;
                        srv_nx = 1'b0;
                    end
                end
            end
            SCORED: if (tick) begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = SERVE;
                    hold_nx  = '0;
                    px_nx    = srv ? SX2_Q : SX1_Q;
                    py_nx    = SY_Q;
                end else begin
                    hold_nx = hold_cnt + HW'(1);
                end
            end
            default: state_nx = SERVE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= SERVE;
            px        <= SX1_Q;
            py        <= SY_Q;
            vx        <= '0;
            vy        <= '0;
            srv       <= 1'b0;
            hold_cnt  <= '0;
            vblnk_d   <= 1'b0;
            c1        <= 1'b0;
            c2        <= 1'b0;
            cn        <= 1'b0;
            point_pl1 <= 1'b0;
            point_pl2 <= 1'b0;
        end else begin
            state     <= state_nx;
            px        <= px_nx;
            py        <= py_nx;
            vx        <= vx_nx;
            vy        <= vy_nx;
            srv       <= srv_nx;
            hold_cnt  <= hold_nx;
            vblnk_d   <= vblnk;
            // a flag seen on the tick cycle belongs to the next frame
            c1        <= tick ? pl1_col : (c1 | pl1_col);
            c2        <= tick ? pl2_col : (c2 | pl2_col);
            cn        <= tick ? net_col : (cn | net_col);
            point_pl1 <= pt1_nx;
            point_pl2 <= pt2_nx;
        end
    end

endmodule
